// File: rtl/video_edge_pipeline.sv
// rtl/video_edge_pipeline.sv - RGB to luma, 3x3 Sobel edge pipeline with delay-matched sync
module video_edge_pipeline #(
    parameter int DW        = 8,
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int PIPE      = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          per_frame_vsync,
    input  logic          per_frame_href,
    input  logic          per_frame_clken,
    input  logic [DW-1:0] per_img_red,
    input  logic [DW-1:0] per_img_green,
    input  logic [DW-1:0] per_img_blue,
    input  logic [1:0]    cfg_mode,
    input  logic [DW-1:0] cfg_thresh,
    output logic          post_frame_vsync,
    output logic          post_frame_href,
    output logic          post_frame_clken,
    output logic [DW-1:0] post_img_ch0,
    output logic [DW-1:0] post_img_ch1,
    output logic [DW-1:0] post_img_ch2,
    output logic          post_img_bit,
    output logic [31:0]   stat_edge_cnt
);
    localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int CW = AW + 1;
    localparam int RW = $clog2(IMG_VDISP + 1) + 1;
    localparam int BW = 3 * DW + 3;
    localparam logic [DW-1:0] HALF = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAXV = {DW{1'b1}};
    localparam logic [CW-1:0] HLIM = CW'(IMG_HDISP);

    // The core has a fixed latency of 5; any extra latency is added in front of it.
    logic [BW-1:0] in_bus, dl_bus;
    assign in_bus = {per_frame_vsync, per_frame_href, per_frame_clken,
                     per_img_red, per_img_green, per_img_blue};
    generate
        if (PIPE > 5) begin : g_extra
            logic [BW-1:0] dly [PIPE-5];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE - 5; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= in_bus;
                    for (int i = 1; i < PIPE - 5; i++) dly[i] <= dly[i-1];
                end
            end
            assign dl_bus = dly[PIPE-6];
        end else begin : g_direct
            assign dl_bus = in_bus;
        end
    endgenerate

    logic          vs_i, hr_i, ck_i;
    logic [DW-1:0] r_i, g_i, b_i;
    assign {vs_i, hr_i, ck_i, r_i, g_i, b_i} = dl_bus;

    // vs_q resets high so a frame already in progress at reset release stays blocked.
    logic          vs_q, armed, hr_q, vs_rise, gate, vs_g, hr_g, ck_g, pix_v;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    mode_l;
    logic [DW-1:0] thresh_l;

    assign vs_rise = vs_i & ~vs_q;
    assign gate    = armed | vs_rise;
    assign vs_g    = vs_i & gate;
    assign hr_g    = hr_i & gate;
    assign ck_g    = ck_i & gate;
    assign pix_v   = ck_g & hr_g;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q     <= 1'b1;
            armed    <= 1'b0;
            hr_q     <= 1'b0;
            col      <= '0;
            row      <= '0;
            mode_l   <= '0;
            thresh_l <= '0;
        end else begin
            vs_q <= vs_i;
            hr_q <= hr_g;
            if (vs_rise) begin
                armed    <= 1'b1;
                col      <= pix_v ? CW'(1) : '0;
                row      <= '0;
                mode_l   <= cfg_mode;
                thresh_l <= cfg_thresh;
            end else if (hr_q && !hr_g) begin
                col <= '0;
                if (row != '1) row <= row + 1'b1;
            end else if (pix_v && col != '1) begin
                col <= col + 1'b1;
            end
        end
    end

    logic [DW+7:0] acc;
    assign acc = (DW+8)'(77) * (DW+8)'(r_i) + (DW+8)'(150) * (DW+8)'(g_i)
               + (DW+8)'(29) * (DW+8)'(b_i);

    logic            s1_v;
    logic [DW-1:0]   s1_y;
    logic [CW-1:0]   s1_col, s2_col, s3_col;
    logic [RW-1:0]   s1_row, s2_row, s3_row;
    logic [3*DW-1:0] s1_rgb, s2_rgb, s3_rgb, s4_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_y   <= '0;
            s1_col <= '0;
            s1_row <= '0;
            s1_rgb <= '0;
        end else begin
            s1_v   <= pix_v;
            s1_y   <= DW'(acc >> 8);
            s1_col <= col;
            s1_row <= row;
            s1_rgb <= {r_i, g_i, b_i};
        end
    end

    logic [DW-1:0] lb0 [IMG_HDISP];
    logic [DW-1:0] lb1 [IMG_HDISP];
    logic [AW-1:0] lb_addr;
    logic          lb_ok;
    logic [DW-1:0] lb0_rd, lb1_rd;

    assign lb_addr = s1_col[AW-1:0];
    assign lb_ok   = s1_col < HLIM;
    assign lb0_rd  = lb0[lb_addr];
    assign lb1_rd  = lb1[lb_addr];

    always_ff @(posedge clk) begin
        if (s1_v && lb_ok) begin
            lb0[lb_addr] <= s1_y;
            lb1[lb_addr] <= lb0_rd;
        end
    end

    // Window rows: w0 = two lines up, w1 = one line up, w2 = current; index 2 is newest column.
    logic [2:0][DW-1:0] w0, w1, w2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0     <= '0;
            w1     <= '0;
            w2     <= '0;
            s2_col <= '0;
            s2_row <= '0;
            s2_rgb <= '0;
        end else begin
            if (s1_v) begin
                w0 <= {lb1_rd, w0[2], w0[1]};
                w1 <= {lb0_rd, w1[2], w1[1]};
                w2 <= {s1_y, w2[2], w2[1]};
            end
            s2_col <= s1_col;
            s2_row <= s1_row;
            s2_rgb <= s1_rgb;
        end
    end

    function automatic logic signed [DW+2:0] sx(input logic [DW-1:0] v);
        return $signed({3'b000, v});
    endfunction

    logic signed [DW+2:0] s3_gx, s3_gy;
    logic [DW-1:0]        s3_y, s4_y, s4_mag;
    logic                 s4_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_gx  <= '0;
            s3_gy  <= '0;
            s3_y   <= '0;
            s3_col <= '0;
            s3_row <= '0;
            s3_rgb <= '0;
        end else begin
            s3_gx  <= (sx(w0[2]) + sx(w1[2]) + sx(w1[2]) + sx(w2[2]))
                    - (sx(w0[0]) + sx(w1[0]) + sx(w1[0]) + sx(w2[0]));
            s3_gy  <= (sx(w2[0]) + sx(w2[1]) + sx(w2[1]) + sx(w2[2]))
                    - (sx(w0[0]) + sx(w0[1]) + sx(w0[1]) + sx(w0[2]));
            s3_y   <= w1[1];
            s3_col <= s2_col;
            s3_row <= s2_row;
            s3_rgb <= s2_rgb;
        end
    end

    logic [DW+2:0] ax, ay, sum;
    logic [DW-1:0] mag_c;
    logic          border;
    assign ax     = s3_gx[DW+2] ? DW'(0) - s3_gx : s3_gx;
    assign ay     = s3_gy[DW+2] ? DW'(0) - s3_gy : s3_gy;
    assign sum    = ax + ay;
    assign border = (s3_col < CW'(2)) || (s3_row < RW'(2));
    assign mag_c  = border ? '0 : ((|sum[DW+2:DW]) ? MAXV : sum[DW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s4_mag <= '0;
            s4_bit <= 1'b0;
            s4_y   <= '0;
            s4_rgb <= '0;
        end else begin
            s4_mag <= mag_c;
            s4_bit <= mag_c > thresh_l;
            s4_y   <= s3_y;
            s4_rgb <= s3_rgb;
        end
    end

    logic [4:0][2:0] sd;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sd <= '0;
        else        sd <= {sd[3:0], {vs_g, hr_g, ck_g}};
    end
    assign post_frame_vsync = sd[4][2];
    assign post_frame_href  = sd[4][1];
    assign post_frame_clken = sd[4][0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_img_ch0 <= '0;
            post_img_ch1 <= '0;
            post_img_ch2 <= '0;
            post_img_bit <= 1'b0;
        end else if (sd[3][0]) begin
            post_img_bit <= s4_bit;
            case (mode_l)
                2'd0: begin
                    post_img_ch0 <= s4_y;
                    post_img_ch1 <= HALF;
                    post_img_ch2 <= HALF;
                end
                2'd1: begin
                    post_img_ch0 <= s4_mag;
                    post_img_ch1 <= HALF;
                    post_img_ch2 <= HALF;
                end
                2'd2: begin
                    post_img_ch0 <= {DW{s4_bit}};
                    post_img_ch1 <= '0;
                    post_img_ch2 <= '0;
                end
                default: {post_img_ch0, post_img_ch1, post_img_ch2} <= s4_rgb;
            endcase
        end
    end

    // A rise without an intervening fall clears the count without publishing it.
    logic        pv_q;
    logic [31:0] edge_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q          <= 1'b0;
            edge_cnt      <= '0;
            stat_edge_cnt <= '0;
        end else begin
            pv_q <= post_frame_vsync;
            if (post_frame_vsync && !pv_q) begin
                edge_cnt <= '0;
            end else if (!post_frame_vsync && pv_q) begin
                stat_edge_cnt <= edge_cnt;
                edge_cnt      <= '0;
            end else if (post_frame_clken && post_frame_href && post_img_bit && edge_cnt != '1) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_video_edge_pipeline.sv
// tb/tb_video_edge_pipeline.sv - scoreboard bench for video_edge_pipeline
module tb_video_edge_pipeline;
    localparam int DW = 8;
    localparam int H  = 16;
    localparam int V  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
    logic [DW-1:0] per_img_red = '0, per_img_green = '0, per_img_blue = '0;
    logic [1:0]    cfg_mode = '0;
    logic [DW-1:0] cfg_thresh = '0;
    logic          post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit;
    logic [DW-1:0] post_img_ch0, post_img_ch1, post_img_ch2;
    logic [31:0]   stat_edge_cnt;

    always #5 clk = ~clk;

    video_edge_pipeline #(.DW(DW), .IMG_HDISP(H), .IMG_VDISP(V), .PIPE(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_frame_clken(per_frame_clken),
        .per_img_red(per_img_red), .per_img_green(per_img_green), .per_img_blue(per_img_blue),
        .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken),
        .post_img_ch0(post_img_ch0), .post_img_ch1(post_img_ch1), .post_img_ch2(post_img_ch2),
        .post_img_bit(post_img_bit), .stat_edge_cnt(stat_edge_cnt)
    );

    typedef struct {
        logic [7:0] ch0, ch1, ch2;
        logic       bv;
        logic       chk0;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   n_checks = 0, n_fail = 0, n_pix = 0;
    int   yimg[V][H], rimg[V][H], gimg[V][H], bimg[V][H];
    int   lmode, lth, edge_exp;
    bit   suppress, sync_chk;
    logic [2:0] hist[5];
    int   hist_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (post_frame_clken) begin
            n_checks++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pixel actual=output expected=none");
            end else begin
                me = sbq.pop_front();
                if ((me.chk0 && post_img_ch0 !== me.ch0) || post_img_ch1 !== me.ch1 ||
                    post_img_ch2 !== me.ch2 || post_img_bit !== me.bv) begin
                    n_fail++;
                    $display("FAIL pixel%0d actual=%0d/%0d/%0d/%0d expected=%0d/%0d/%0d/%0d",
                             n_pix, post_img_ch0, post_img_ch1, post_img_ch2, post_img_bit,
                             me.ch0, me.ch1, me.ch2, me.bv);
                end
            end
            n_pix++;
        end
        if (sync_chk) begin
            if (hist_n >= 5)
                check("sync_delay", 32'({post_frame_vsync, post_frame_href, post_frame_clken}),
                      32'(hist[4]));
            for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {per_frame_vsync, per_frame_href, per_frame_clken};
            hist_n++;
        end
    end

    function automatic exp_t model(input int c, input int r);
        exp_t e;
        int mag, gx, gy, yc;
        mag = 0;
        if (c >= 2 && r >= 2) begin
            gx = (yimg[r-2][c] + 2*yimg[r-1][c] + yimg[r][c])
               - (yimg[r-2][c-2] + 2*yimg[r-1][c-2] + yimg[r][c-2]);
            gy = (yimg[r][c-2] + 2*yimg[r][c-1] + yimg[r][c])
               - (yimg[r-2][c-2] + 2*yimg[r-2][c-1] + yimg[r-2][c]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (mag > 255) mag = 255;
        end
        yc = (c >= 1 && r >= 1) ? yimg[r-1][c-1] : 0;
        e.bv   = (mag > lth);
        e.chk0 = 1'b1;
        case (lmode)
            0: begin e.ch0 = 8'(yc); e.ch1 = 8'd128; e.ch2 = 8'd128; e.chk0 = (c >= 1 && r >= 1); end
            1: begin e.ch0 = 8'(mag); e.ch1 = 8'd128; e.ch2 = 8'd128; end
            2: begin e.ch0 = e.bv ? 8'd255 : 8'd0; e.ch1 = 8'd0; e.ch2 = 8'd0; end
            default: begin e.ch0 = 8'(rimg[r][c]); e.ch1 = 8'(gimg[r][c]); e.ch2 = 8'(bimg[r][c]); end
        endcase
        return e;
    endfunction

    task automatic drive(input logic vs, input logic hr, input logic ck, input int r, input int g, input int b);
        @(posedge clk); #1;
        per_frame_vsync = vs;
        per_frame_href  = hr;
        per_frame_clken = ck;
        per_img_red     = 8'(r);
        per_img_green   = 8'(g);
        per_img_blue    = 8'(b);
    endtask

    // kind: 0 flat 100, 1 vertical step 0|200, 2 random RGB
    task automatic run_frame(input int kind, input int mode, input int th, input bit gaps,
                             input int chg_row, input int rst_row);
        exp_t e;
        cfg_mode   = 2'(mode);
        cfg_thresh = 8'(th);
        lmode = mode; lth = th; edge_exp = 0; suppress = 0;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                case (kind)
                    0: begin rimg[r][c] = 100; gimg[r][c] = 100; bimg[r][c] = 100; end
                    1: begin
                        rimg[r][c] = (c >= H/2) ? 200 : 0;
                        gimg[r][c] = rimg[r][c];
                        bimg[r][c] = rimg[r][c];
                    end
                    default: begin
                        rimg[r][c] = $urandom_range(0, 255);
                        gimg[r][c] = $urandom_range(0, 255);
                        bimg[r][c] = $urandom_range(0, 255);
                    end
                endcase
                yimg[r][c] = (77*rimg[r][c] + 150*gimg[r][c] + 29*bimg[r][c]) >> 8;
            end
        end
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        for (int r = 0; r < V; r++) begin
            if (r == chg_row) cfg_mode = 2'd2;
            if (r == rst_row) begin
                @(posedge clk); #1;
                rst_n = 1'b0;
                sbq.delete();
                suppress = 1;
                @(negedge clk);
                check("rst_sync", 32'({post_frame_vsync, post_frame_href, post_frame_clken}), 0);
                check("rst_ch0", 32'(post_img_ch0), 0);
                check("rst_ch1", 32'(post_img_ch1), 0);
                check("rst_ch2", 32'(post_img_ch2), 0);
                check("rst_bit", 32'(post_img_bit), 0);
                check("rst_stat", stat_edge_cnt, 0);
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            for (int c = 0; c < H; c++) begin
                if (gaps) repeat ($urandom_range(0, 2)) drive(1, 1, 0, 0, 0, 0);
                drive(1, 1, 1, rimg[r][c], gimg[r][c], bimg[r][c]);
                if (!suppress) begin
                    e = model(c, r);
                    sbq.push_back(e);
                    if (e.bv) edge_exp++;
                end
            end
            repeat (4) drive(1, 0, 0, 0, 0, 0);
        end
        repeat (2) drive(1, 0, 0, 0, 0, 0);
        repeat (12) drive(0, 0, 0, 0, 0, 0);
        check("stat_edge_cnt", stat_edge_cnt, suppress ? 32'd0 : 32'(edge_exp));
        check("drain", 32'(sbq.size()), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sync_chk = 0; hist_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_sync", 32'({post_frame_vsync, post_frame_href, post_frame_clken}), 0);
        check("reset_data", {8'h0, post_img_ch0, post_img_ch1, post_img_ch2}, 0);
        check("reset_stat", stat_edge_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) drive(0, 0, 0, 0, 0, 0);

        run_frame(0, 0, 0,   0, -1, -1);
        run_frame(0, 1, 0,   0, -1, -1);
        run_frame(1, 1, 254, 0, -1, -1);
        run_frame(1, 2, 254, 0, -1, -1);
        check("stat_step_hand", stat_edge_cnt, 32'(2*(V-2)));
        run_frame(1, 2, 255, 0, -1, -1);
        run_frame(1, 0, 254, 0, 3, -1);
        run_frame(1, 2, 254, 0, -1, -1);
        sync_chk = 1; hist_n = 0;
        run_frame(2, 3, 20,  1, -1, -1);
        sync_chk = 0;
        run_frame(2, 3, 20,  0, -1, 4);
        sync_chk = 1; hist_n = 0;
        run_frame(2, 1, 100, 1, -1, -1);
        sync_chk = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
